// File: rtl/alu_issue_ctrl.sv
// Sequential issue controller: accepts R-type ops, drives the external 8-op ALU, returns the result.
// Optional build macro ALU_ZERO_FLAG_EN adds the registered rsp_zero output.
module alu_issue_ctrl #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_sel,
  input  logic [31:0]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
`ifdef ALU_ZERO_FLAG_EN
  output logic             rsp_zero,
`endif
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       dec_sel;
  logic             dec_illegal;
  logic [TAG_W-1:0] tag_q;
  logic             illegal_q;
  logic [31:0]      result_d;
  logic             accept;
  logic             handoff;

  // R-type funct to ALU select; unsupported functs run as AND and are flagged
  always_comb begin
    dec_sel     = 3'b000;
    dec_illegal = 1'b0;
    case (req_funct)
      6'h24:        dec_sel = 3'b000;
      6'h25:        dec_sel = 3'b001;
      6'h20, 6'h21: dec_sel = 3'b010;
      6'h26:        dec_sel = 3'b011;
      6'h22, 6'h23: dec_sel = 3'b100;
      6'h02:        dec_sel = 3'b101;
      6'h00:        dec_sel = 3'b110;
      6'h27:        dec_sel = 3'b111;
      default:      dec_illegal = 1'b1;
    endcase
  end

  assign accept   = (state_q == IDLE) && req_valid && req_ready;
  assign handoff  = (state_q == RESP) && rsp_valid && rsp_ready;
  assign result_d = illegal_q ? 32'h0 : alu_out;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (handoff) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake flags follow the next state so they are valid from the first cycle of each state
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
    end
  end

  // Operand/select registers double as the ALU drive, so they hold outside EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a     <= 32'h0;
      alu_b     <= 32'h0;
      alu_sel   <= 3'b000;
      tag_q     <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      alu_a     <= req_a;
      alu_b     <= req_b;
      alu_sel   <= dec_sel;
      tag_q     <= req_tag;
      illegal_q <= dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_result  <= 32'h0;
      rsp_tag     <= '0;
      rsp_illegal <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
      rsp_zero    <= 1'b0;
`endif
    end else if (state_q == EXEC) begin
      rsp_result  <= result_d;
      rsp_tag     <= tag_q;
      rsp_illegal <= illegal_q;
`ifdef ALU_ZERO_FLAG_EN
      rsp_zero    <= (result_d == 32'h0);
`endif
    end
  end

  // Saturating count of handed-off responses
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
    end else if (handoff && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
// Define ALU_ZERO_FLAG_EN for both files to exercise rsp_zero.
module tb_alu_issue_ctrl;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_funct;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_sel;
  logic [31:0]      alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;
`ifdef ALU_ZERO_FLAG_EN
  logic             rsp_zero;
`endif
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
`ifdef ALU_ZERO_FLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .op_count(op_count)
  );

  // Reference 8-op ALU
  always_comb begin
    case (alu_sel)
      3'd0:    alu_out = alu_a & alu_b;
      3'd1:    alu_out = alu_a | alu_b;
      3'd2:    alu_out = alu_a + alu_b;
      3'd3:    alu_out = alu_a ^ alu_b;
      3'd4:    alu_out = alu_a - alu_b;
      3'd5:    alu_out = alu_a >> alu_b[4:0];
      3'd6:    alu_out = alu_a << alu_b[4:0];
      default: alu_out = ~(alu_a | alu_b);
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag, input logic [31:0] res);
`ifdef ALU_ZERO_FLAG_EN
    chk(tag, 64'(rsp_zero), 64'(res == 32'h0));
`else
    if (res === 32'hx) chk(tag, 64'(rsp_result), 64'(res));
`endif
  endtask

  // One op with immediate response acceptance
  task automatic do_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t, input logic [2:0] sel,
                       input logic [31:0] res, input logic ill);
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b; req_tag = t;
    tick();
    req_valid = 1'b0;
    chk({nm, "_sel"}, 64'(alu_sel), 64'(sel));
    chk({nm, "_alu_a"}, 64'(alu_a), 64'(a));
    chk({nm, "_exec_ready"}, 64'(req_ready), 64'd0);
    chk({nm, "_exec_valid"}, 64'(rsp_valid), 64'd0);
    tick();
    chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({nm, "_result"}, 64'(rsp_result), 64'(res));
    chk({nm, "_tag"}, 64'(rsp_tag), 64'(t));
    chk({nm, "_illegal"}, 64'(rsp_illegal), 64'(ill));
    chk_zero({nm, "_zero"}, res);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_count++;
    chk({nm, "_done_valid"}, 64'(rsp_valid), 64'd0);
    chk({nm, "_done_ready"}, 64'(req_ready), 64'd1);
    chk({nm, "_count"}, 64'(op_count), 64'(exp_count));
    chk({nm, "_sel_hold"}, 64'(alu_sel), 64'(sel));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0;
    req_tag = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_count", 64'(op_count), 64'd0);
    chk("rst_result", 64'(rsp_result), 64'd0);
    chk("rst_sel", 64'(alu_sel), 64'd0);
    reset = 1'b0;
    tick();

    do_op("add",  6'h20, 32'd7,          32'd5,  4'd3, 3'b010, 32'd12,         1'b0);
    do_op("sub",  6'h22, 32'd0,          32'd1,  4'd4, 3'b100, 32'hFFFF_FFFF,  1'b0);
    do_op("sll",  6'h00, 32'd1,          32'd4,  4'd5, 3'b110, 32'h10,         1'b0);
    do_op("nor",  6'h27, 32'd0,          32'd0,  4'd6, 3'b111, 32'hFFFF_FFFF,  1'b0);
    do_op("and",  6'h24, 32'hFF00,       32'h0FF0, 4'd7, 3'b000, 32'h0F00,     1'b0);
    do_op("xor",  6'h26, 32'hFF,         32'h0F, 4'd8, 3'b011, 32'hF0,         1'b0);
    do_op("srl",  6'h02, 32'h8000_0000,  32'd31, 4'd9, 3'b101, 32'd1,          1'b0);
    do_op("addu", 6'h21, 32'hFFFF_FFFF,  32'd1,  4'd10, 3'b010, 32'd0,         1'b0);
    do_op("subu", 6'h23, 32'd5,          32'd3,  4'd11, 3'b100, 32'd2,         1'b0);

    // Response back-pressure: everything held, no new accept, count frozen
    req_valid = 1'b1; req_funct = 6'h25; req_a = 32'hF0; req_b = 32'h0F; req_tag = 4'd12;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_result", 64'(rsp_result), 64'hFF);
      chk("bp_tag", 64'(rsp_tag), 64'd12);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_count", 64'(op_count), 64'(exp_count));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_count++;
    chk("bp_count_inc", 64'(op_count), 64'(exp_count));
    chk("bp_ready_back", 64'(req_ready), 64'd1);

    do_op("illegal", 6'h3F, 32'd5, 32'd6, 4'd13, 3'b000, 32'd0, 1'b1);

    // Back-to-back: second op waits for the first handshake
    req_valid = 1'b1; req_funct = 6'h20; req_a = 32'd1; req_b = 32'd2; req_tag = 4'd1;
    tick();
    req_funct = 6'h20; req_a = 32'd3; req_b = 32'd4; req_tag = 4'd2;
    chk("b2b_exec_ready", 64'(req_ready), 64'd0);
    tick();
    chk("b2b_rsp1_valid", 64'(rsp_valid), 64'd1);
    chk("b2b_rsp1_result", 64'(rsp_result), 64'd3);
    chk("b2b_rsp_ready0", 64'(req_ready), 64'd0);
    tick();
    chk("b2b_no_accept", 64'(alu_a), 64'd1);
    chk("b2b_rsp1_hold", 64'(rsp_tag), 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_count++;
    chk("b2b_idle_ready", 64'(req_ready), 64'd1);
    chk("b2b_idle_valid", 64'(rsp_valid), 64'd0);
    tick();
    req_valid = 1'b0;
    chk("b2b_op2_alu_a", 64'(alu_a), 64'd3);
    chk("b2b_op2_ready", 64'(req_ready), 64'd0);
    tick();
    chk("b2b_rsp2_valid", 64'(rsp_valid), 64'd1);
    chk("b2b_rsp2_result", 64'(rsp_result), 64'd7);
    chk("b2b_rsp2_tag", 64'(rsp_tag), 64'd2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_count++;
    chk("b2b_count", 64'(op_count), 64'(exp_count));

    // Reset during EXEC discards the op and clears the counter
    req_valid = 1'b1; req_funct = 6'h26; req_a = 32'hA5; req_b = 32'h5A; req_tag = 4'd14;
    tick();
    req_valid = 1'b0;
    chk("rst_mid_exec_sel", 64'(alu_sel), 64'd3);
    reset = 1'b1; rsp_ready = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 0;
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    chk("rst_mid_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_count", 64'(op_count), 64'd0);
    chk("rst_mid_sel", 64'(alu_sel), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
      chk("rst_mid_count_hold", 64'(op_count), 64'(exp_count));
    end
    rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
